// File: rtl/usr_burst_nbit.sv
// N-bit universal shift register with rotate, arithmetic shift and clear modes,
// plus a burst engine that repeats one shift op for a programmed number of steps.
module usr_burst_nbit #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       select,
   input  logic [WIDTH-1:0] parallelin,
   input  logic             left,
   input  logic             right,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] parallelout,
   output logic             serial_out,
   output logic             busy,
   output logic             done
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [2:0] OP_HOLD = 3'b000;
   localparam logic [2:0] OP_SHR  = 3'b001;
   localparam logic [2:0] OP_SHL  = 3'b010;
   localparam logic [2:0] OP_LOAD = 3'b011;
   localparam logic [2:0] OP_ROR  = 3'b100;
   localparam logic [2:0] OP_ROL  = 3'b101;
   localparam logic [2:0] OP_ASR  = 3'b110;
   localparam logic [2:0] OP_CLR  = 3'b111;

   state_t           state_r;
   logic [2:0]       op_r;
   logic [CNT_W-1:0] cnt_r;
   logic [2:0]       op_s;
   logic [WIDTH-1:0] nxt_s;
   logic             so_nxt_s;
   logic             accept_s;
   logic             empty_s;

   function automatic logic is_shift(input logic [2:0] op);
      case (op)
         OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_ASR: is_shift = 1'b1;
         default:                                is_shift = 1'b0;
      endcase
   endfunction

   // Next register/serial value for the active op; during a burst the latched op wins over select
   always_comb begin
      op_s     = (state_r == RUN) ? op_r : select;
      nxt_s    = parallelout;
      so_nxt_s = serial_out;
      case (op_s)
         OP_HOLD: nxt_s = parallelout;
         OP_SHR: begin
            nxt_s    = {right, parallelout[WIDTH-1:1]};
            so_nxt_s = parallelout[0];
         end
         OP_SHL: begin
            nxt_s    = {parallelout[WIDTH-2:0], left};
            so_nxt_s = parallelout[WIDTH-1];
         end
         OP_LOAD: nxt_s = parallelin;
         OP_ROR: begin
            nxt_s    = {parallelout[0], parallelout[WIDTH-1:1]};
            so_nxt_s = parallelout[0];
         end
         OP_ROL: begin
            nxt_s    = {parallelout[WIDTH-2:0], parallelout[WIDTH-1]};
            so_nxt_s = parallelout[WIDTH-1];
         end
         OP_ASR: begin
            nxt_s    = {parallelout[WIDTH-1], parallelout[WIDTH-1:1]};
            so_nxt_s = parallelout[0];
         end
         OP_CLR:  nxt_s = {WIDTH{1'b0}};
         default: nxt_s = parallelout;
      endcase
      // start with a non-shift op is ignored entirely, whatever count says
      accept_s = (state_r == IDLE) && start && is_shift(select) && (count != {CNT_W{1'b0}});
      empty_s  = (state_r == IDLE) && start && is_shift(select) && (count == {CNT_W{1'b0}});
   end

   // Burst FSM and all registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         op_r        <= OP_HOLD;
         cnt_r       <= {CNT_W{1'b0}};
         parallelout <= {WIDTH{1'b0}};
         serial_out  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  op_r    <= select;
                  cnt_r   <= count;
                  busy    <= 1'b1;
                  done    <= 1'b0;
                  state_r <= RUN;
               end else if (empty_s) begin
                  done <= 1'b1;
               end else begin
                  parallelout <= nxt_s;
                  serial_out  <= so_nxt_s;
                  done        <= 1'b0;
               end
            end
            RUN: begin
               parallelout <= nxt_s;
               serial_out  <= so_nxt_s;
               cnt_r       <= cnt_r - CNT_W'(1);
               if (cnt_r == CNT_W'(1)) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_r <= IDLE;
               end else begin
                  done <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule
